// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_if
// Description : Bus bundle between the execute-stage controller and the
//               alu_muldiv block. The controller drives operands, operation
//               code and start; the ALU returns the combinational result,
//               flags, the mul/div handshake and the HI/LO contents.
// Ports       : srca/srcb (WIDTH) operands, alucontrol (4) operation,
//               start (1) mul/div launch, aluout (WIDTH) result,
//               zero/overflow (1) flags, busy/done (1) mul/div status,
//               hi/lo (WIDTH) architectural HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic             start;
  logic [WIDTH-1:0] aluout;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Controller side
  modport master (
    output srca, srcb, alucontrol, start,
    input  aluout, zero, overflow, busy, done, hi, lo
  );

  // ALU side
  modport slave (
    input  srca, srcb, alucontrol, start,
    output aluout, zero, overflow, busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : MIPS execute-stage ALU. Logic/arithmetic/compare operations
//               are purely combinational. MULT/MULTU/DIV/DIVU run on an
//               iterative radix-2 unit (shift-add multiply, restoring divide)
//               taking WIDTH+1 cycles and writing the HI/LO registers.
// Ports       : clk     - rising-edge clock
//               reset_n - synchronous active-low reset
//               bus     - alu_muldiv_if.slave (operands, op code, start,
//                         result, flags, busy/done, hi/lo)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_muldiv_if.slave  bus
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] c_AND   = 4'b0000;
  localparam logic [3:0] c_OR    = 4'b0001;
  localparam logic [3:0] c_ADD   = 4'b0010;
  localparam logic [3:0] c_SLTU  = 4'b0011;
  localparam logic [3:0] c_ANDN  = 4'b0100;
  localparam logic [3:0] c_ORN   = 4'b0101;
  localparam logic [3:0] c_SUB   = 4'b0110;
  localparam logic [3:0] c_SLT   = 4'b0111;
  localparam logic [3:0] c_XOR   = 4'b1000;
  localparam logic [3:0] c_NOR   = 4'b1001;
  localparam logic [3:0] c_MFHI  = 4'b1010;
  localparam logic [3:0] c_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Combinational ALU
  // --------------------------------------------------------------------------
  logic             w_invert;
  logic [WIDTH-1:0] w_bm;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_result;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  assign w_invert  = (bus.alucontrol == c_SUB) || (bus.alucontrol == c_SLT) ||
                     (bus.alucontrol == c_SLTU);
  assign w_bm      = w_invert ? ~bus.srcb : bus.srcb;
  // One extra bit keeps the carry so the unsigned borrow is available.
  assign w_sum_ext = {1'b0, bus.srca} + {1'b0, w_bm} + {{WIDTH{1'b0}}, w_invert};
  assign w_sum     = w_sum_ext[WIDTH-1:0];
  // Overflow of A + B': operands agree in sign but the sum does not.
  assign w_ovf     = (bus.srca[MSB] == w_bm[MSB]) && (w_sum[MSB] != bus.srca[MSB]);
  // Sign of the difference corrected for overflow gives a true signed compare.
  assign w_slt     = w_sum[MSB] ^ w_ovf;
  assign w_sltu    = ~w_sum_ext[WIDTH];

  always_comb begin
    w_result = '0;
    case (bus.alucontrol)
      c_AND:   w_result = bus.srca & bus.srcb;
      c_OR:    w_result = bus.srca | bus.srcb;
      c_ADD:   w_result = w_sum;
      c_SLTU:  w_result = {{(WIDTH-1){1'b0}}, w_sltu};
      c_ANDN:  w_result = bus.srca & ~bus.srcb;
      c_ORN:   w_result = bus.srca | ~bus.srcb;
      c_SUB:   w_result = w_sum;
      c_SLT:   w_result = {{(WIDTH-1){1'b0}}, w_slt};
      c_XOR:   w_result = bus.srca ^ bus.srcb;
      c_NOR:   w_result = ~(bus.srca | bus.srcb);
      c_MFHI:  w_result = r_hi;
      c_MFLO:  w_result = r_lo;
      default: w_result = '0;   // mul/div codes act only through start
    endcase
  end

  assign bus.aluout   = w_result;
  assign bus.zero     = (w_result == '0);
  assign bus.overflow = ((bus.alucontrol == c_ADD) || (bus.alucontrol == c_SUB)) && w_ovf;

  // --------------------------------------------------------------------------
  // Iterative multiply / divide
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;     // negate product / quotient at the end
  logic               r_neg_r;     // negate remainder (dividend was negative)
  logic               r_div0;
  logic [2*WIDTH-1:0] r_acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_opb;       // multiplicand or divisor magnitude
  logic               r_busy;
  logic               r_done;

  logic               w_launch;
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_neg;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_launch = bus.start && (bus.alucontrol[3:2] == 2'b11) && (r_state == S_IDLE);
  assign w_signed = ~bus.alucontrol[0];
  assign w_neg_a  = w_signed && bus.srca[MSB];
  assign w_neg_b  = w_signed && bus.srcb[MSB];
  assign w_abs_a  = w_neg_a ? (~bus.srca + 1'b1) : bus.srca;
  assign w_abs_b  = w_neg_b ? (~bus.srcb + 1'b1) : bus.srcb;

  // Shift-add: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right, keeping the carry as the new MSB.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // keep the trial difference only when it does not go negative.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qbit};

  assign w_acc_neg  = ~r_acc + 1'b1;
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_is_div <= bus.alucontrol[1];
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_div0   <= bus.alucontrol[1] && (bus.srcb == '0);
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
            if (bus.alucontrol[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_a};
              r_opb <= w_abs_b;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_b};
              r_opb <= w_abs_a;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            // Divide by zero leaves the all-ones quotient unsigned; negating
            // the remainder magnitude restores the raw dividend.
            r_lo <= (r_neg_q && !r_div0) ? (~w_quo + 1'b1) : w_quo;
            r_hi <= r_neg_r ? (~w_rem + 1'b1) : w_rem;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_acc_neg : r_acc;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Directed self-checking bench for alu_muldiv (WIDTH=32 and
//               WIDTH=8 instances) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(32)) bus32();
  alu_muldiv_if #(.WIDTH(8))  bus8();

  alu_muldiv #(.WIDTH(32)) u_dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32.slave));
  alu_muldiv #(.WIDTH(8))  u_dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.alucontrol = op;
    bus32.srca       = a;
    bus32.srcb       = b;
    #1;
  endtask

  task automatic launch32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.alucontrol = op;
    bus32.srca       = a;
    bus32.srcb       = b;
    bus32.start      = 1'b1;
    tick();
    bus32.start      = 1'b0;
  endtask

  task automatic wait_done32(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus32.done && n < 100);
  endtask

  task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    launch32(op, a, b);
    wait_done32(n);
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_hilo"}, {bus32.hi, bus32.lo}, {ehi, elo});
  endtask

  initial begin
    int n;
    int done_seen;

    reset_n          = 1'b0;
    bus32.start      = 1'b0;
    bus32.alucontrol = OP_AND;
    bus32.srca       = '0;
    bus32.srcb       = '0;
    bus8.start       = 1'b0;
    bus8.alucontrol  = OP_AND;
    bus8.srca        = '0;
    bus8.srcb        = '0;
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_busy", 64'(bus32.busy), 64'd0);
    check("rst_done", 64'(bus32.done), 64'd0);
    check("rst_hilo", {bus32.hi, bus32.lo}, 64'd0);

    // Combinational operations
    comb(OP_SUB, 32'd5, 32'd7);
    check("sub_5_7", 64'(bus32.aluout), 64'hFFFF_FFFE);
    check("sub_5_7_zero", 64'(bus32.zero), 64'd0);
    comb(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf", 64'(bus32.overflow), 64'd1);
    check("add_ovf_res", 64'(bus32.aluout), 64'h8000_0000);
    comb(OP_SLT, 32'h8000_0000, 32'd1);
    check("slt_min_1", 64'(bus32.aluout), 64'd1);
    check("slt_no_ovf_flag", 64'(bus32.overflow), 64'd0);
    comb(OP_SLTU, 32'h8000_0000, 32'd1);
    check("sltu_min_1", 64'(bus32.aluout), 64'd0);
    comb(OP_SUB, 32'd9, 32'd9);
    check("sub_9_9_zero", 64'(bus32.zero), 64'd1);
    comb(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF);
    check("nor", 64'(bus32.aluout), 64'hF0F0_FF00);
    comb(OP_MULT, 32'd3, 32'd4);
    check("mulcode_res0", 64'(bus32.aluout), 64'd0);
    check("mulcode_no_launch", 64'(bus32.busy), 64'd0);

    // Multiply / divide
    run32("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    tick();
    check("done_one_cycle", 64'(bus32.done), 64'd0);
    run32("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run32("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run32("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run32("divu_9_0", OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run32("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run32("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Busy behaviour: MULTU 6x7 with a stray DIV start and operand changes
    launch32(OP_MULTU, 32'd6, 32'd7);
    check("busy_after_start", 64'(bus32.busy), 64'd1);
    bus32.alucontrol = OP_DIV;
    bus32.srca       = 32'd100;
    bus32.srcb       = 32'd3;
    bus32.start      = 1'b1;
    tick();
    bus32.start      = 1'b0;
    comb(OP_MFLO, 32'd1, 32'd2);
    check("mflo_busy_prev", 64'(bus32.aluout), 64'h8000_0000);
    comb(OP_MFHI, 32'd1, 32'd2);
    check("mfhi_busy_prev", 64'(bus32.aluout), 64'd0);
    comb(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    check("and_busy", 64'(bus32.aluout), 64'h0000_F000);
    wait_done32(n);
    check("busy_op_lat", 64'(n + 1), 64'd33);
    check("busy_op_hilo", {bus32.hi, bus32.lo}, 64'd42);
    tick();
    check("stray_start_ignored", 64'(bus32.busy), 64'd0);

    // Reset in the middle of a MULT
    launch32(OP_MULT, 32'd5, 32'd6);
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_busy", 64'(bus32.busy), 64'd0);
    check("midrst_hilo", {bus32.hi, bus32.lo}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.done) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    run32("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // New start accepted in the done cycle
    launch32(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    check("b2b_busy", 64'(bus32.busy), 64'd1);
    wait_done32(n);
    check("b2b_lat", 64'(n), 64'd33);
    check("b2b_hilo", {bus32.hi, bus32.lo}, 64'h0000_0001_0000_0000);

    // WIDTH=8 instance
    bus8.alucontrol = OP_MULTU;
    bus8.srca       = 8'hFF;
    bus8.srcb       = 8'hFF;
    bus8.start      = 1'b1;
    tick();
    bus8.start      = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus8.done && n < 50);
    check("w8_lat", 64'(n), 64'd9);
    check("w8_hilo", 64'({bus8.hi, bus8.lo}), 64'h0000_0000_0000_FE01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
